// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage.
// Pure declarations: no latency, no backpressure.
package pwm_pkg;

  localparam int PWM_CNT_W        = 8;
  localparam int NUM_OUT          = 16;
  localparam int DEFAULT_PRESCALE = 13;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
  typedef logic [NUM_OUT-1:0]   out_vec_t;

  localparam pwm_cnt_t DUTY_FULL = 8'hFF;
  localparam pwm_cnt_t CNT_LAST  = 8'hFF;

  // Full-scale duty is forced high so the pin never drops for the last count.
  function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: tick is high combinationally while the count sits at PRESCALE-1.
// Free-running, no backpressure; PRESCALE=1 gives a tick every cycle.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0] prescale_cnt_q;
  logic [7:0] prescale_cnt_d;

  always_comb begin
    tick           = (prescale_cnt_q == PRE_LAST);
    prescale_cnt_d = tick ? 8'd0 : prescale_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_cnt_q <= 8'd0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// 16 registered pins, each static low/high or a shared 8-bit PWM; 1-cycle latency
// from inputs to pins, duty latched only at period wrap; no backpressure.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic     tick;
  logic     wrap;
  logic     pwm_sig;
  out_vec_t en;
  out_vec_t pm;

  pwm_cnt_t pwm_cnt_q,      pwm_cnt_d;
  pwm_cnt_t duty_shadow_q,  duty_shadow_d;
  logic     period_start_q, period_start_d;
  out_vec_t out_q,          out_d;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en = {en_reg_out_15_8, en_reg_out_7_0};
  assign pm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    wrap           = tick && (pwm_cnt_q == CNT_LAST);
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_shadow_d  = wrap ? pwm_duty_cycle : duty_shadow_q;
    period_start_d = wrap;
    pwm_sig        = pwm_level(pwm_cnt_q, duty_shadow_q);
    // Enable dominates; PWM-mode bits follow the shared waveform, others sit high.
    out_d          = en & (~pm | {NUM_OUT{pwm_sig}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: two instances (PRESCALE 1 and 13) share inputs and
// are checked every cycle against a cycle-count model plus directed literal checks.
module tb_pwm_output_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en, pm;
  logic [7:0]  duty;
  logic [15:0] out1, out13;
  logic        ps1, ps13;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pwm_output_stage #(.PRESCALE(1)) dut1 (
    .clk (clk), .rst_n (rst_n),
    .en_reg_out_7_0 (en[7:0]),  .en_reg_out_15_8 (en[15:8]),
    .en_reg_pwm_7_0 (pm[7:0]),  .en_reg_pwm_15_8 (pm[15:8]),
    .pwm_duty_cycle (duty), .out (out1), .period_start (ps1)
  );

  pwm_output_stage #(.PRESCALE(13)) dut13 (
    .clk (clk), .rst_n (rst_n),
    .en_reg_out_7_0 (en[7:0]),  .en_reg_out_15_8 (en[15:8]),
    .en_reg_pwm_7_0 (pm[7:0]),  .en_reg_pwm_15_8 (pm[15:8]),
    .pwm_duty_cycle (duty), .out (out13), .period_start (ps13)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: the counter value is just (edges since reset / prescale) mod 256;
  // the duty shadow is whatever duty was present on each full-period boundary.
  int unsigned n_edges;
  logic [7:0]  sh1, sh13;
  logic [15:0] m_out1, m_out13;
  logic        m_ps1, m_ps13;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges = 0; sh1 = 8'h00; sh13 = 8'h00;
      m_out1 = 16'h0; m_out13 = 16'h0; m_ps1 = 1'b0; m_ps13 = 1'b0;
    end else begin
      int c1, c13;
      bit s1, s13;
      c1  = n_edges % 256;
      c13 = (n_edges / 13) % 256;
      s1  = (sh1 == 8'hFF) || (c1 < int'(sh1));
      s13 = (sh13 == 8'hFF) || (c13 < int'(sh13));
      m_out1  = en & (~pm | {16{s1}});
      m_out13 = en & (~pm | {16{s13}});
      n_edges = n_edges + 1;
      m_ps1   = (n_edges % 256) == 0;
      m_ps13  = (n_edges % (256 * 13)) == 0;
      if (m_ps1)  sh1  = duty;
      if (m_ps13) sh13 = duty;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_out_p1",  {16'h0, out1},  {16'h0, m_out1});
      chk("model_ps_p1",   {31'h0, ps1},   {31'h0, m_ps1});
      chk("model_out_p13", {16'h0, out13}, {16'h0, m_out13});
      chk("model_ps_p13",  {31'h0, ps13},  {31'h0, m_ps13});
    end
  end

  task automatic wait_ps(input bit slow, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if ((slow ? ps13 : ps1) === 1'b1) found = 1'b1;
    end
    chk(name, {31'h0, found}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, nps, first_ps;
    bit even_ok, odd_ok;
    rst_n = 1'b0; en = '0; pm = '0; duty = '0;

    repeat (3) @(negedge clk);
    chk("reset_out_p1",  {16'h0, out1},  32'h0);
    chk("reset_out_p13", {16'h0, out13}, 32'h0);
    chk("reset_ps_p1",   {31'h0, ps1},   32'h0);
    rst_n = 1'b1; chk_on = 1'b1;

    // Static modes
    en = 16'h00F0; pm = 16'h0000;
    @(negedge clk);
    chk("static_en_f0", {16'h0, out1}, 32'h00F0);
    chk("static_en_f0_p13", {16'h0, out13}, 32'h00F0);
    en = 16'h0000; pm = 16'hFFFF;
    @(negedge clk);
    chk("static_pm_only", {16'h0, out1}, 32'h0000);

    // 50% duty, prescale 1
    en = 16'h0001; pm = 16'h0001; duty = 8'h80;
    wait_ps(1'b0, 300, "wait_ps_50");
    chk("duty50_before_edge", {31'h0, out1[0]}, 32'd0);
    hi = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 1) chk("duty50_rise_after_ps", {31'h0, out1[0]}, 32'd1);
      if (k == 256) chk("duty50_next_ps", {31'h0, ps1}, 32'd1);
      hi += int'(out1[0]);
    end
    chk("duty50_high_cycles", hi, 32'd128);

    // Duty extremes
    duty = 8'h00;
    wait_ps(1'b0, 300, "wait_ps_0");
    hi = 0;
    for (int k = 0; k < 768; k++) begin @(negedge clk); hi += int'(out1[0]); end
    chk("duty00_high_cycles", hi, 32'd0);
    duty = 8'hFF;
    wait_ps(1'b0, 300, "wait_ps_ff");
    hi = 0;
    for (int k = 0; k < 768; k++) begin @(negedge clk); hi += int'(out1[0]); end
    chk("dutyff_high_cycles", hi, 32'd768);

    // Mid-period duty change, prescale 13
    duty = 8'h40;
    wait_ps(1'b1, 3400, "wait_ps13_40");
    hi = 0; nps = 0;
    for (int k = 1; k <= 3328; k++) begin
      @(negedge clk);
      if (k == 416) duty = 8'hC0;
      hi += int'(out13[0]);
      nps += int'(ps13);
    end
    chk("p13_cur_high", hi, 32'd832);
    chk("p13_spacing1", {31'h0, ps13}, 32'd1);
    chk("p13_ps_count1", nps, 32'd1);
    hi = 0; nps = 0;
    for (int k = 1; k <= 3328; k++) begin
      @(negedge clk);
      hi += int'(out13[0]);
      nps += int'(ps13);
    end
    chk("p13_next_high", hi, 32'd2496);
    chk("p13_spacing2", {31'h0, ps13}, 32'd1);

    // Mixed static / PWM bits
    en = 16'hFFFF; pm = 16'hAAAA; duty = 8'h40;
    wait_ps(1'b0, 300, "wait_ps_mix");
    hi = 0; even_ok = 1'b1; odd_ok = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 1) chk("mix_rise_all", {16'h0, out1}, 32'hFFFF);
      hi += int'(out1[1]);
      if ((out1 & 16'h5555) != 16'h5555) even_ok = 1'b0;
      if ((out1 & 16'hAAAA) != 16'h0000 && (out1 & 16'hAAAA) != 16'hAAAA) odd_ok = 1'b0;
    end
    chk("mix_odd_high", hi, 32'd64);
    chk("mix_even_const", {31'h0, even_ok}, 32'd1);
    chk("mix_odd_phase", {31'h0, odd_ok}, 32'd1);

    // Mid-operation asynchronous reset
    en = 16'hFFFF; pm = 16'h0000;
    repeat (2) @(negedge clk);
    chk("pre_reset_high", {16'h0, out1}, 32'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_p1",  {16'h0, out1},  32'h0);
    chk("async_rst_out_p13", {16'h0, out13}, 32'h0);
    chk("async_rst_ps",      {30'h0, ps1, ps13}, 32'h0);
    en = 16'h0001; pm = 16'h0001; duty = 8'h80;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi = 0; first_ps = 0;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      if (ps1 && first_ps == 0) first_ps = k;
      if (k <= 256) hi += int'(out1[0]);
      if (k == 257) chk("post_rst_first_rise", {31'h0, out1[0]}, 32'd1);
    end
    chk("post_rst_first_ps", first_ps, 32'd256);
    chk("post_rst_low_period", hi, 32'd0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
